idct_row: RTL and testbench
===========================

# idct_row

Single-row 8-point inverse DCT for the JPEG path. It accepts one 72-bit row of coefficients in the forward DCT row-stage output packing and rebuilds eight unsigned 8-bit samples in the forward stage's input packing. The block is sequential: one pixel is evaluated per cycle, 8 cycles per row. Valid/ready handshakes on both sides let it sit between a coefficient buffer and the pixel/row writer.

## Interface
Parameters:
- `FRAC`, 8: fractional bits of the cosine ROM and of the rounding shift.
- `CW`, 12: signed cosine ROM entry width.

Ports:
- `clk`  in  1  single clock; all flops rise-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  72  coefficients X0..X7, 9-bit two's complement each; X0 = [71:63] … X7 = [8:0].
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a row.
- `out_data`  out  64  pixels p0..p7, unsigned 8-bit each; p0 = [63:56] … p7 = [7:0].
- `out_valid`  out  1  `out_data` holds a complete row.
- `out_ready`  in  1  downstream accepts the row.

## Operation
- Math: p[n] = clamp0_255((Σk X[k]·T[n][k] + 2^(FRAC−1)) >>> FRAC).
  - T[n][k] = round(2^(FRAC+1) · C_k · cos((2n+1)kπ/16)), with C_0 = 1/√2 and C_k = 1 otherwise.
  - The shift is arithmetic, so it floors.
  - T0 = 362, T[0][1] = 502.
- Widths:
  - Each product is 9×12 signed, giving 21 bits.
  - The accumulator is 24-bit signed, so the sum cannot overflow.
  - Clamp after the shift: negative → 0, >255 → 255.
- X7 is processed like any other coefficient, even though the forward stage drives it to 0.
- FSM, 3 states:
  - IDLE: `in_ready`=1. On `in_valid`, latch all 8 coefficients, set n=0, go to CALC.
  - CALC: `in_ready`=0. Each cycle write p[n] into the output register slot n, then n++. After n=7 go to DONE.
  - DONE: `out_valid`=1, `out_data` stable. On `out_ready`, go to IDLE.
- `in_ready` and `out_valid` are decoded from state only. There are no combinational in→out paths.
- The coefficient register is written only on acceptance. The output register is cleared on acceptance.
- Reset values: state IDLE, n=0, `out_valid`=0, `out_data`=0, coefficient register 0. `in_ready` is 1 once reset deasserts.
- Reset asserted mid-CALC or mid-DONE: the row is lost and outputs immediately return to their reset values.
- `out_ready` outside DONE is ignored. `in_valid` outside IDLE is ignored; the upstream holds the row.

## Timing
- Row accepted at edge E:
  - p0..p7 are written at edges E+1..E+8.
  - `out_valid` rises after E+8, i.e. 8 cycles after acceptance.
- With `out_ready` held high:
  - DONE → IDLE at E+9.
  - The next row can be accepted at E+10.
  - Throughput is 1 row per 10 cycles.
- Backpressure: DONE holds indefinitely, with `out_data` bit-stable.

## Structure
- Package `jpeg_pkg`:
  - `COEF_W`=9, `PIX_W`=8, `ACC_W`=24.
  - the 8×8 ROM constant T (signed `CW`), shared with future column-stage blocks.
- Sub-module `idct_dot8` (combinational):
  - inputs: 8 coefficients and n.
  - selects ROM row n, forms the 8 products and adder tree, rounds and clamps.
  - output: one 8-bit pixel.
- The top level holds the FSM, the n counter, the coefficient register and the output register.

## Test plan
- DC only, X0=90, rest 0 → after 8 cycles `out_data`=64'h7F7F_7F7F_7F7F_7F7F (32708>>>8=127).
- Clamping, reset-mid-operation and backpressure:
  - X0=−10 → all pixels 0x00.
  - X0=181 → all pixels 0xFF.
  - Assert `rst_n`=0 at cycle E+4 → `out_valid`=0 and `out_data`=0 asynchronously. After release, `in_ready`=1 and no output appears.
  - `out_ready`=0 for 20 cycles in DONE → `out_valid` and `out_data` unchanged. Then `out_ready`=1 for one cycle → IDLE. An immediate `in_valid` is accepted, giving 10-cycle spacing.
- X1=100 only → p0=196 (50328>>>8). p7 clamps to 0. Pixels are antisymmetric about 0 before the clamp.
- Round-trip: random 8-byte rows through the forward row DCT into this block → each pixel within ±8 of the original (forward stage truncates 9 LSBs). Repeat with back-to-back `in_valid` held high to verify 1 row / 10 cycles.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath types, widths and the 8x8 IDCT cosine ROM.
// Imported by the row stage now and by column-stage blocks later.
package jpeg_pkg;

  localparam int COEF_W = 9;
  localparam int PIX_W  = 8;
  localparam int ACC_W  = 24;
  localparam int ROM_W  = 12;
  localparam int ROW_N  = 8;

  // Element 7 is X0 / p0 so the packed row matches the bus bit order.
  typedef logic [ROW_N-1:0][COEF_W-1:0] coef_row_t;
  typedef logic [ROW_N-1:0][PIX_W-1:0]  pix_row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } idct_state_t;

  // T[n][k] = round(2^9 * C_k * cos((2n+1)k*pi/16)), C_0 = 1/sqrt(2).
  localparam logic signed [ROM_W-1:0] T_ROM [8][8] = '{
    '{ 12'sd362,  12'sd502,  12'sd473,  12'sd426,
       12'sd362,  12'sd284,  12'sd196,  12'sd100 },
    '{ 12'sd362,  12'sd426,  12'sd196, -12'sd100,
      -12'sd362, -12'sd502, -12'sd473, -12'sd284 },
    '{ 12'sd362,  12'sd284, -12'sd196, -12'sd502,
      -12'sd362,  12'sd100,  12'sd473,  12'sd426 },
    '{ 12'sd362,  12'sd100, -12'sd473, -12'sd284,
       12'sd362,  12'sd426, -12'sd196, -12'sd502 },
    '{ 12'sd362, -12'sd100, -12'sd473,  12'sd284,
       12'sd362, -12'sd426, -12'sd196,  12'sd502 },
    '{ 12'sd362, -12'sd284, -12'sd196,  12'sd502,
      -12'sd362, -12'sd100,  12'sd473, -12'sd426 },
    '{ 12'sd362, -12'sd426,  12'sd196,  12'sd100,
      -12'sd362,  12'sd502, -12'sd473,  12'sd284 },
    '{ 12'sd362, -12'sd502,  12'sd473, -12'sd426,
       12'sd362, -12'sd284,  12'sd196, -12'sd100 }
  };

  function automatic logic signed [ROM_W-1:0] rom_t(
    input logic [2:0] n,
    input logic [2:0] k
  );
    return T_ROM[n][k];
  endfunction

endpackage

// File: rtl/idct_dot8.sv
// Combinational 8-tap dot product: one IDCT output pixel.
// Ports: coef (row X0..X7), n (pixel index) -> pix (clamped 8-bit).
module idct_dot8
  import jpeg_pkg::*;
#(
  parameter int FRAC = 8,
  parameter int CW   = 12
) (
  input  coef_row_t        coef,
  input  logic [2:0]       n,
  output logic [PIX_W-1:0] pix
);

  localparam int HALF    = 1 << (FRAC - 1);
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  logic signed [COEF_W-1:0] c_k [8];
  logic signed [CW-1:0]     t_k [8];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  sh;

  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      c_k[k] = coef[7-k];
      t_k[k] = CW'(rom_t(n, 3'(k)));
      acc = acc + ACC_W'(c_k[k]) * ACC_W'(t_k[k]);
    end
  end

  // Arithmetic shift floors, so the rounding bias sits before it.
  assign rnd = acc + ACC_W'(HALF);
  assign sh  = rnd >>> FRAC;

  always_comb begin
    pix = sh[PIX_W-1:0];
    if (sh < 0)
      pix = '0;
    else if (sh > PIX_MAX)
      pix = '1;
  end

endmodule

// File: rtl/idct_row.sv
// Sequential 8-point row IDCT, one pixel per cycle, valid/ready both sides.
// Ports: clk, rst_n, in_data/in_valid/in_ready, out_data/out_valid/out_ready.
module idct_row
  import jpeg_pkg::*;
#(
  parameter int FRAC = 8,
  parameter int CW   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  idct_state_t      state;
  logic [2:0]       n;
  coef_row_t        coef_q;
  pix_row_t         pix_q;
  logic [PIX_W-1:0] pix;

  idct_dot8 #(
    .FRAC(FRAC),
    .CW  (CW)
  ) u_dot (
    .coef(coef_q),
    .n   (n),
    .pix (pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      n      <= '0;
      coef_q <= '0;
      pix_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            coef_q <= in_data;
            pix_q  <= '0;
            n      <= '0;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          // p0 lives in the top byte.
          pix_q[3'd7 - n] <= pix;
          n <= n + 3'd1;
          if (n == 3'd7)
            state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = pix_q;

endmodule

// File: tb/tb_idct_row.sv
// Directed bench for idct_row: vector table plus reset,
// backpressure and throughput sequences.
module tb_idct_row;

  logic        clk;
  logic        rst_n;
  logic [71:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_pass;
  int n_total;

  idct_row dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [71:0] din;
    logic [63:0] dout;
  } vec_t;

  function automatic logic [71:0] row9(
    input int a, input int b, input int c, input int d,
    input int e, input int f, input int g, input int h
  );
    return {9'(a), 9'(b), 9'(c), 9'(d),
            9'(e), 9'(f), 9'(g), 9'(h)};
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a row, return once accepted; flags timeout.
  task automatic send(input logic [71:0] d);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) chk("send_timeout", 64'd1, 64'd0);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count cycles from acceptance to out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid) break;
      step();
      lat = i;
    end
    if (!out_valid) chk("out_timeout", 64'd1, 64'd0);
  endtask

  vec_t vecs[$];
  int   lat;
  int   bad;
  int   acc_cyc[$];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    vecs.push_back('{"dc90", row9(90,0,0,0,0,0,0,0),
                     64'h7F7F_7F7F_7F7F_7F7F});
    vecs.push_back('{"dc_neg", row9(-10,0,0,0,0,0,0,0),
                     64'h0000_0000_0000_0000});
    vecs.push_back('{"dc_sat", row9(181,0,0,0,0,0,0,0),
                     64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{"x1_100", row9(0,100,0,0,0,0,0,0),
                     64'hC4A6_6F27_0000_0000});
    vecs.push_back('{"x0x2", row9(128,0,-50,0,0,0,0,0),
                     64'h598F_DBFF_FFDB_8F59});
    vecs.push_back('{"x0x7", row9(128,0,0,0,0,0,0,40),
                     64'hC589_F867_FF72_E1A5});
    vecs.push_back('{"zero", row9(0,0,0,0,0,0,0,0),
                     64'h0000_0000_0000_0000});

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      send(vecs[i].din);
      wait_out(lat);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'd8);
      chk(vecs[i].name, out_data, vecs[i].dout);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({vecs[i].name, "_release"}, 64'(out_valid), 64'd0);
    end

    // Reset in the middle of a calculation drops the row.
    send(vecs[0].din);
    for (int i = 0; i < 3; i++) step();
    chk("mid_in_ready", 64'(in_ready), 64'd0);
    chk("mid_partial", 64'(out_data != 0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) bad++;
      step();
    end
    chk("mid_no_output", 64'(bad), 64'd0);

    // Backpressure: DONE holds with stable data.
    send(vecs[4].din);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid || out_data !== vecs[4].dout) bad++;
      step();
    end
    chk("bp_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    in_data   = vecs[5].din;
    in_valid  = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_accepted", 64'(in_ready), 64'd0);
    wait_out(lat);
    chk("bp_lat", 64'(lat), 64'd8);
    chk("bp_data", out_data, vecs[5].dout);
    out_ready = 1'b1;
    step();

    // Back-to-back rows: in_valid and out_ready held high.
    in_data  = vecs[3].din;
    in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) acc_cyc.push_back(c);
      if (out_valid && out_data !== vecs[3].dout) bad++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("tp_data", 64'(bad), 64'd0);
    chk("tp_count", 64'(acc_cyc.size() >= 3), 64'd1);
    if (acc_cyc.size() >= 3) begin
      chk("tp_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd10);
      chk("tp_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd10);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
